// File: rtl/spi_slave_responder.sv
// SPI target: oversampled pins, MSB-first byte packing into a 32-bit word,
// and a preloaded 1-4 byte response shifted out on MISO.
module spi_slave_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_bytes_valid_i,
    input  logic        tx_load_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_bytes_valid_o,
    output logic        rx_byte_strobe_o,
    output logic        frame_done_o,
    output logic        overrun_o
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_q, cs_q;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic frame_start, frame_end;

    logic [31:0] shadow_data;
    logic [2:0]  shadow_cnt;
    logic [2:0]  tx_left;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [2:0]  bit_cnt;
    logic        rise_seen;
    logic [7:0]  first_byte, next_byte;

    function automatic logic [7:0] pick_byte(input logic [31:0] d,
                                             input logic [2:0] n);
        case (n)
            3'd1:    return d[7:0];
            3'd2:    return d[15:8];
            3'd3:    return d[23:16];
            default: return d[31:24];
        endcase
    endfunction

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

    assign first_byte = (shadow_cnt == 3'd0) ? IDLE_FILL
                                             : pick_byte(shadow_data, shadow_cnt);
    assign next_byte  = (tx_left == 3'd0) ? IDLE_FILL
                                          : pick_byte(shadow_data, tx_left);

    // Pin synchronisers plus one extra flop for edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b1;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Frame sequencing: chip-select edges open and close a frame.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        tx_ready_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_ready_o = 1'b1;
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift datapath, response shadow and receive word packing.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            spi_miso_o       <= 1'b1;
            rx_data_o        <= '0;
            rx_bytes_valid_o <= '0;
            rx_byte_strobe_o <= 1'b0;
            frame_done_o     <= 1'b0;
            overrun_o        <= 1'b0;
            shadow_data      <= '0;
            shadow_cnt       <= '0;
            tx_left          <= '0;
            tx_sr            <= '0;
            rx_sr            <= '0;
            bit_cnt          <= '0;
            rise_seen        <= 1'b0;
        end else begin
            rx_byte_strobe_o <= 1'b0;
            frame_done_o     <= 1'b0;
            if (frame_start) begin
                rx_data_o        <= '0;
                rx_bytes_valid_o <= '0;
                overrun_o        <= 1'b0;
                bit_cnt          <= '0;
                rise_seen        <= 1'b0;
                rx_sr            <= '0;
                tx_sr            <= first_byte;
                spi_miso_o       <= first_byte[7];
                tx_left          <= (shadow_cnt == 3'd0) ? 3'd0
                                                         : shadow_cnt - 3'd1;
            end else if (frame_end) begin
                frame_done_o <= 1'b1;
                shadow_cnt   <= '0;
                spi_miso_o   <= 1'b1;
                bit_cnt      <= '0;
                rise_seen    <= 1'b0;
            end else if (state_q == ST_ACTIVE) begin
                if (sclk_rise) begin
                    rx_sr     <= {rx_sr[6:0], mosi_s};
                    bit_cnt   <= bit_cnt + 3'd1;
                    rise_seen <= 1'b1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_o        <= {rx_data_o[23:0], rx_sr[6:0], mosi_s};
                        rx_byte_strobe_o <= 1'b1;
                        if (rx_bytes_valid_o == 3'd4) overrun_o <= 1'b1;
                        else rx_bytes_valid_o <= rx_bytes_valid_o + 3'd1;
                        tx_sr <= next_byte;
                        if (tx_left != 3'd0) tx_left <= tx_left - 3'd1;
                    end
                end else if (sclk_fall && rise_seen) begin
                    spi_miso_o <= tx_sr[~bit_cnt];
                    rise_seen  <= 1'b0;
                end
            end else if (tx_load_i) begin
                shadow_data <= tx_data_i;
                shadow_cnt  <= (tx_bytes_valid_i > 3'd4) ? 3'd4 : tx_bytes_valid_i;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: directed SPI frames with a queue-based
// scoreboard; monitors compare MISO bytes, byte strobes and frame ends.
`timescale 1ns/1ps
module tb_spi_slave_responder;

    localparam int HALF = 80;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        spi_clk = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] tx_data = '0;
    logic [2:0]  tx_bv = '0;
    logic        tx_load = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic [2:0]  rx_bv;
    logic        rx_strobe;
    logic        frame_done;
    logic        overrun;

    int n_checks = 0;
    int n_pass = 0;

    exp_t       exp_rx[$];
    exp_t       exp_done[$];
    logic [7:0] exp_miso[$];
    logic [7:0] mbuf[8];

    spi_slave_responder dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .spi_clk_i        (spi_clk),
        .spi_cs_n_i       (spi_cs_n),
        .spi_mosi_i       (spi_mosi),
        .spi_miso_o       (spi_miso),
        .tx_data_i        (tx_data),
        .tx_bytes_valid_i (tx_bv),
        .tx_load_i        (tx_load),
        .tx_ready_o       (tx_ready),
        .rx_data_o        (rx_data),
        .rx_bytes_valid_o (rx_bv),
        .rx_byte_strobe_o (rx_strobe),
        .frame_done_o     (frame_done),
        .overrun_o        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_rx(input logic [31:0] d, input logic [2:0] c,
                           input logic o);
        exp_t e;
        e.d = d; e.c = c; e.o = o;
        exp_rx.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] d, input logic [2:0] c,
                             input logic o);
        exp_t e;
        e.d = d; e.c = c; e.o = o;
        exp_done.push_back(e);
    endtask

    task automatic load(input logic [31:0] d, input logic [2:0] n);
        @(negedge clk);
        tx_data = d;
        tx_bv   = n;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Mode-3 master: MOSI changes on the falling edge, sampled on rising.
    task automatic spi_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_clk  = 1'b0;
            spi_mosi = mbuf[i/8][7-(i%8)];
            #(HALF);
            spi_clk = 1'b1;
            #(HALF);
        end
    endtask

    task automatic spi_frame(input int nbits);
        @(negedge clk);
        spi_cs_n = 1'b0;
        #(HALF);
        spi_bits(nbits);
        #(HALF);
        spi_cs_n = 1'b1;
        #(2*HALF);
    endtask

    // Strobe and frame-end monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (rx_strobe) begin
            if (exp_rx.size() == 0) begin
                n_checks++;
                $display("FAIL rx_strobe_unexpected: got strobe with rx_data %h, none expected", rx_data);
            end else begin
                e = exp_rx.pop_front();
                chk("strobe_rx_data", rx_data, e.d);
                chk("strobe_rx_cnt", {29'd0, rx_bv}, {29'd0, e.c});
                chk("strobe_overrun", {31'd0, overrun}, {31'd0, e.o});
            end
        end
        if (frame_done) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                $display("FAIL frame_done_unexpected: got pulse with rx_data %h, none expected", rx_data);
            end else begin
                e = exp_done.pop_front();
                chk("done_rx_data", rx_data, e.d);
                chk("done_rx_cnt", {29'd0, rx_bv}, {29'd0, e.c});
                chk("done_overrun", {31'd0, overrun}, {31'd0, e.o});
                chk("done_tx_ready", {31'd0, tx_ready}, 32'd1);
            end
        end
    end

    // MISO monitor: assembles bytes on SCLK rising edges within a frame.
    logic       cs_last = 1'b1;
    int         mbits = 0;
    logic [7:0] mbyte = '0;
    always @(posedge spi_clk or spi_cs_n) begin
        if (spi_cs_n != cs_last) begin
            cs_last = spi_cs_n;
            mbits   = 0;
        end else if (!spi_cs_n) begin
            mbyte = {mbyte[6:0], spi_miso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_miso.size() == 0) begin
                    n_checks++;
                    $display("FAIL miso_unexpected: got byte %h, none expected", mbyte);
                end else begin
                    chk("miso_byte", {24'd0, mbyte}, {24'd0, exp_miso.pop_front()});
                end
            end
        end
    end

    initial begin
        #23;
        chk("rst_miso", {31'd0, spi_miso}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_rx_cnt", {29'd0, rx_bv}, 32'd0);
        chk("rst_strobe", {31'd0, rx_strobe}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Four-byte response, four-byte frame.
        load(32'hA1B2C3D4, 3'd4);
        mbuf[0] = 8'h11; mbuf[1] = 8'h22; mbuf[2] = 8'h33; mbuf[3] = 8'h44;
        exp_miso.push_back(8'hA1); exp_miso.push_back(8'hB2);
        exp_miso.push_back(8'hC3); exp_miso.push_back(8'hD4);
        push_rx(32'h00000011, 3'd1, 1'b0);
        push_rx(32'h00001122, 3'd2, 1'b0);
        push_rx(32'h00112233, 3'd3, 1'b0);
        push_rx(32'h11223344, 3'd4, 1'b0);
        push_done(32'h11223344, 3'd4, 1'b0);
        spi_frame(32);

        // Two-byte response exhausted by a three-byte frame.
        load(32'h000000C3, 3'd2);
        mbuf[0] = 8'hAA; mbuf[1] = 8'hBB; mbuf[2] = 8'hCC;
        exp_miso.push_back(8'h00); exp_miso.push_back(8'hC3);
        exp_miso.push_back(8'hFF);
        push_rx(32'h000000AA, 3'd1, 1'b0);
        push_rx(32'h0000AABB, 3'd2, 1'b0);
        push_rx(32'h00AABBCC, 3'd3, 1'b0);
        push_done(32'h00AABBCC, 3'd3, 1'b0);
        spi_frame(24);

        // No load: idle fill only.
        mbuf[0] = 8'h5A;
        exp_miso.push_back(8'hFF);
        push_rx(32'h0000005A, 3'd1, 1'b0);
        push_done(32'h0000005A, 3'd1, 1'b0);
        spi_frame(8);

        // Six-byte frame overruns the 4-byte window.
        for (int i = 0; i < 6; i++) begin
            mbuf[i] = 8'(i + 1);
            exp_miso.push_back(8'hFF);
        end
        push_rx(32'h00000001, 3'd1, 1'b0);
        push_rx(32'h00000102, 3'd2, 1'b0);
        push_rx(32'h00010203, 3'd3, 1'b0);
        push_rx(32'h01020304, 3'd4, 1'b0);
        push_rx(32'h02030405, 3'd4, 1'b1);
        push_rx(32'h03040506, 3'd4, 1'b1);
        push_done(32'h03040506, 3'd4, 1'b1);
        spi_frame(48);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Partial second byte is discarded; overrun cleared at frame start.
        mbuf[0] = 8'h77; mbuf[1] = 8'hE5;
        exp_miso.push_back(8'hFF);
        push_rx(32'h00000077, 3'd1, 1'b0);
        push_done(32'h00000077, 3'd1, 1'b0);
        spi_frame(13);
        chk("partial_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("partial_rx_cnt", {29'd0, rx_bv}, 32'd1);

        // Reset mid-byte, then a normal frame with an over-range byte count.
        load(32'h12345678, 3'd4);
        mbuf[0] = 8'hF0; mbuf[1] = 8'hFF;
        exp_miso.push_back(8'h12);
        push_rx(32'h000000F0, 3'd1, 1'b0);
        @(negedge clk);
        spi_cs_n = 1'b0;
        #(2*HALF);
        chk("active_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("miso_before_sclk", {31'd0, spi_miso}, 32'd0);
        spi_bits(11);
        rstn = 1'b0;
        spi_cs_n = 1'b1;
        #1;
        chk("midrst_miso", {31'd0, spi_miso}, 32'd1);
        chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("midrst_rx_data", rx_data, 32'd0);
        chk("midrst_rx_cnt", {29'd0, rx_bv}, 32'd0);
        chk("midrst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);

        load(32'hCAFEF00D, 3'd7);
        mbuf[0] = 8'h9A; mbuf[1] = 8'hBC;
        exp_miso.push_back(8'hCA); exp_miso.push_back(8'hFE);
        push_rx(32'h0000009A, 3'd1, 1'b0);
        push_rx(32'h00009ABC, 3'd2, 1'b0);
        push_done(32'h00009ABC, 3'd2, 1'b0);
        spi_frame(16);

        repeat (10) @(negedge clk);
        chk("left_exp_rx", exp_rx.size(), 32'd0);
        chk("left_exp_done", exp_done.size(), 32'd0);
        chk("left_exp_miso", exp_miso.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
